mux_arb8: RTL and testbench

MUX_ARB8 -- requirements
Module: mux_arb8

---
 rtl/mux_arb8.sv | 132 +++++++++++++
 tb/tb_mux_arb8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mux_arb8.sv
// Round-robin arbiter over eight requesters with an 8:1 data mux.
// A grant is held for at most MAX_HOLD beats or until the owner drops its request.
module mux_arb8 #(
  parameter int W        = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     req,
  input  logic [8*W-1:0] din,
  output logic [7:0]     gnt,
  output logic [2:0]     sel,
  output logic [W-1:0]   dout,
  output logic           dvalid,
  input  logic           dready,
  output logic           busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam logic [7:0] HOLD_C = 8'(MAX_HOLD);

  // Circular priority search starting at p; returns {found, index}.
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic logic [3:0] pick_f(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t     state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [7:0] cnt_r, cnt_s;
  logic [2:0] sel_r, sel_s;
  logic [7:0] gnt_r, gnt_s;
  logic       busy_r, busy_s;
  logic [3:0] pick_s;
  logic       own_s, dvalid_s, beat_s, rel_s;

  // Next-state, grant and beat-count logic.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    cnt_s    = cnt_r;
    sel_s    = sel_r;
    gnt_s    = gnt_r;
    busy_s   = busy_r;
    pick_s   = pick_f(req, ptr_r);
    own_s    = (state_r == OWN);
    dvalid_s = own_s & req[sel_r];
    beat_s   = dvalid_s & dready;
    rel_s    = own_s & (~req[sel_r] | (beat_s & ((cnt_r + 8'd1) == HOLD_C)));
    case (state_r)
      IDLE: begin
        if (pick_s[3]) begin
          state_s = OWN;
          sel_s   = pick_s[2:0];
          gnt_s   = 8'd1 << pick_s[2:0];
          cnt_s   = 8'd0;
          busy_s  = 1'b1;
        end else begin
          gnt_s  = 8'd0;
          busy_s = 1'b0;
        end
      end
      OWN: begin
        if (beat_s) begin
          cnt_s = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r;
        end
        // sel keeps the last owner after release; only ptr moves on.
        if (rel_s) begin
          state_s = IDLE;
          gnt_s   = 8'd0;
          busy_s  = 1'b0;
          ptr_s   = sel_r + 3'd1;
        end else begin
          state_s = OWN;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 8'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over any beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      cnt_r   <= 8'd0;
      sel_r   <= 3'd0;
      gnt_r   <= 8'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      sel_r   <= sel_s;
      gnt_r   <= gnt_s;
      busy_r  <= busy_s;
    end
  end

  // Data mux driven from the registered select; forced to zero when idle.
  always_comb begin
    if (own_s) begin
      dout = din[sel_r*W +: W];
    end else begin
      dout = {W{1'b0}};
    end
  end

  assign gnt    = gnt_r;
  assign sel    = sel_r;
  assign busy   = busy_r;
  assign dvalid = dvalid_s;

endmodule

// File: tb/tb_mux_arb8.sv
// Random and directed bench for mux_arb8; two instances (MAX_HOLD 4 and 1)
// share the stimulus and are each checked against an owner/pointer model.
module tb_mux_arb8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic           dready;
  logic [7:0]     gnt_o   [2];
  logic [2:0]     sel_o   [2];
  logic [W-1:0]   dout_o  [2];
  logic           dvalid_o[2];
  logic           busy_o  [2];

  int n_checks = 0;
  int n_errors = 0;
  int hold   [2] = '{4, 1};
  int m_owner[2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_sel  [2];

  always #5 clk = ~clk;

  mux_arb8 #(.W(W), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt_o[0]), .sel(sel_o[0]),
    .dout(dout_o[0]), .dvalid(dvalid_o[0]), .dready(dready), .busy(busy_o[0])
  );

  mux_arb8 #(.W(W), .MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt_o[1]), .sel(sel_o[1]),
    .dout(dout_o[1]), .dvalid(dvalid_o[1]), .dready(dready), .busy(busy_o[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic rand_din();
    for (int i = 0; i < 8; i++) din[i*W +: W] = W'($urandom);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_cnt[k]   = 0;
      m_sel[k]   = 0;
    end
  endtask

  // Expected outputs follow directly from who owns the bus right now.
  task automatic check_outputs();
    logic [7:0]   e_gnt;
    logic         e_dv;
    logic [W-1:0] e_dout;
    for (int k = 0; k < 2; k++) begin
      if (m_owner[k] < 0) begin
        e_gnt  = 8'h00;
        e_dv   = 1'b0;
        e_dout = '0;
      end else begin
        e_gnt  = 8'(1 << m_owner[k]);
        e_dv   = req[m_owner[k]];
        e_dout = din[m_owner[k]*W +: W];
      end
      check_eq($sformatf("gnt[%0d]", k), 64'(gnt_o[k]), 64'(e_gnt));
      check_eq($sformatf("sel[%0d]", k), 64'(sel_o[k]), 64'(m_sel[k]));
      check_eq($sformatf("busy[%0d]", k), 64'(busy_o[k]), 64'(m_owner[k] >= 0));
      check_eq($sformatf("dvalid[%0d]", k), 64'(dvalid_o[k]), 64'(e_dv));
      check_eq($sformatf("dout[%0d]", k), 64'(dout_o[k]), 64'(e_dout));
      check_eq($sformatf("onehot[%0d]", k), 64'($countones(gnt_o[k]) <= 1), 64'(1));
    end
  endtask

  // Advance the model by one clock using the inputs now on the pins.
  task automatic model_step();
    int i;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = -1;
        m_ptr[k]   = 0;
        m_cnt[k]   = 0;
        m_sel[k]   = 0;
      end else if (m_owner[k] < 0) begin
        for (int off = 0; off < 8; off++) begin
          i = (m_ptr[k] + off) % 8;
          if (req[i] && m_owner[k] < 0) begin
            m_owner[k] = i;
            m_sel[k]   = i;
            m_cnt[k]   = 0;
          end
        end
      end else if (!req[m_owner[k]]) begin
        m_ptr[k]   = (m_owner[k] + 1) % 8;
        m_owner[k] = -1;
      end else if (dready) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == hold[k]) begin
          m_ptr[k]   = (m_owner[k] + 1) % 8;
          m_owner[k] = -1;
        end
      end
    end
  endtask

  task automatic run(input logic r, input logic [7:0] q, input logic d, input int n, input bit rnd);
    repeat (n) begin
      rst    = r;
      req    = q;
      dready = d;
      if (rnd) rand_din();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] q;
    rst    = 1'b1;
    req    = 8'h00;
    dready = 1'b0;
    rand_din();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    run(1'b1, 8'h00, 1'b0, 1, 1'b0);

    // single requester, then full rotation
    run(1'b0, 8'h01, 1'b1, 14, 1'b0);
    run(1'b0, 8'hFF, 1'b1, 24, 1'b0);
    // pointer wrap
    run(1'b1, 8'h00, 1'b0, 1, 1'b0);
    run(1'b0, 8'h04, 1'b1, 6, 1'b0);
    run(1'b0, 8'h05, 1'b1, 16, 1'b0);
    // stall on owner 5
    run(1'b1, 8'h00, 1'b0, 1, 1'b0);
    run(1'b0, 8'h20, 1'b1, 2, 1'b0);
    run(1'b0, 8'h20, 1'b0, 3, 1'b0);
    run(1'b0, 8'h20, 1'b1, 4, 1'b0);
    // early drop by owner 6, next grant must start at 7
    run(1'b1, 8'h00, 1'b0, 1, 1'b0);
    run(1'b0, 8'h40, 1'b1, 3, 1'b0);
    run(1'b0, 8'h00, 1'b1, 1, 1'b0);
    run(1'b0, 8'hFF, 1'b1, 3, 1'b0);
    // reset in the middle of a transfer
    run(1'b1, 8'h00, 1'b0, 1, 1'b0);
    run(1'b0, 8'h01, 1'b1, 3, 1'b0);
    run(1'b1, 8'h01, 1'b1, 1, 1'b0);
    run(1'b0, 8'h01, 1'b1, 3, 1'b0);

    q = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) q = 8'($urandom & $urandom);
      run(1'($urandom_range(0, 63) == 0), q, 1'($urandom_range(0, 3) != 0), 1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
